// File: rtl/count_stream_checker_if.sv
// Sample stream into the count checker: strobe plus data word.
// The transmitter side drives, the checker side only observes.
interface count_stream_checker_if #(
  parameter int WIDTH = 8
) ();
  logic             en;
  logic [WIDTH-1:0] data_in;

  modport master (
    output en,
    output data_in
  );

  modport slave (
    input en,
    input data_in
  );
endinterface

// File: rtl/count_stream_checker.sv
// Receive-side checker for a free-running +1 count stream.
// Hunts, syncs, locks with a flywheel, and drops lock on repeated slips.
module count_stream_checker #(
  parameter int WIDTH    = 8,
  parameter int LOCK_CNT = 4,
  parameter int LOSS_CNT = 3,
  parameter int ERR_W    = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  count_stream_checker_if.slave  rx,
  input  logic                   clear,
  output logic                   locked,
  output logic                   err_pulse,
  output logic [ERR_W-1:0]       err_count,
  output logic [1:0]             state,
  output logic [WIDTH-1:0]       expected
);

  localparam int GW = $clog2(LOCK_CNT + 1);
  localparam int BW = $clog2(LOSS_CNT + 1);

  localparam logic [GW-1:0]    GOOD_END = GW'(LOCK_CNT);
  localparam logic [BW-1:0]    BAD_END  = BW'(LOSS_CNT);
  localparam logic [ERR_W-1:0] ERR_MAX  = '1;
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

  typedef enum logic [1:0] {
    HUNT   = 2'b00,
    SYNC   = 2'b01,
    LOCKED = 2'b10,
    SLIP   = 2'b11
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] exp_q, exp_d;
  logic [GW-1:0]    good_q, good_d;
  logic [BW-1:0]    bad_q, bad_d;
  logic             pulse_q, pulse_d;
  logic [ERR_W-1:0] cnt_q, cnt_d;

  logic             match;
  logic             err_hit;
  logic [GW-1:0]    good_nxt;
  logic [BW-1:0]    bad_nxt;

  assign match    = (rx.data_in == exp_q);
  assign good_nxt = good_q + GW'(1);
  assign bad_nxt  = bad_q + BW'(1);

  always_comb begin
    state_d = state_q;
    exp_d   = exp_q;
    good_d  = good_q;
    bad_d   = bad_q;
    err_hit = 1'b0;
    if (rx.en) begin
      unique case (state_q)
        HUNT: begin
          exp_d   = rx.data_in + ONE;
          good_d  = '0;
          state_d = SYNC;
        end
        SYNC: begin
          // re-seed every sample until enough matches in a row
          exp_d = rx.data_in + ONE;
          if (match) begin
            if (good_nxt == GOOD_END) begin
              good_d  = '0;
              state_d = LOCKED;
            end else begin
              good_d = good_nxt;
            end
          end else begin
            good_d = '0;
          end
        end
        LOCKED: begin
          exp_d = exp_q + ONE;
          if (!match) begin
            err_hit = 1'b1;
            bad_d   = BW'(1);
            state_d = SLIP;
          end
        end
        SLIP: begin
          exp_d = exp_q + ONE;
          if (match) begin
            bad_d   = '0;
            state_d = LOCKED;
          end else begin
            err_hit = 1'b1;
            if (bad_nxt == BAD_END) begin
              bad_d   = '0;
              state_d = HUNT;
            end else begin
              bad_d = bad_nxt;
            end
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  always_comb begin
    pulse_d = err_hit;
    cnt_d   = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (err_hit && (cnt_q != ERR_MAX)) begin
      cnt_d = cnt_q + ERR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= HUNT;
      exp_q   <= '0;
      good_q  <= '0;
      bad_q   <= '0;
      pulse_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      exp_q   <= exp_d;
      good_q  <= good_d;
      bad_q   <= bad_d;
      pulse_q <= pulse_d;
      cnt_q   <= cnt_d;
    end
  end

  assign locked    = state_q[1];
  assign err_pulse = pulse_q;
  assign err_count = cnt_q;
  assign state     = state_q;
  assign expected  = exp_q;

endmodule

// File: tb/tb_count_stream_checker.sv
// Directed plus randomized bench for count_stream_checker.
// Two instances share one stream: 8-bit and 2-bit error counters.
module tb_count_stream_checker;

  localparam int WIDTH    = 8;
  localparam int LOCK_CNT = 4;
  localparam int LOSS_CNT = 3;

  logic clk;
  logic rst_n;
  logic clear;

  count_stream_checker_if #(.WIDTH(WIDTH)) rx ();

  logic       locked_a, pulse_a;
  logic [7:0] cnt_a;
  logic [1:0] state_a;
  logic [7:0] exp_a;

  logic       locked_b, pulse_b;
  logic [1:0] cnt_b;
  logic [1:0] state_b;
  logic [7:0] exp_b;

  count_stream_checker #(
    .WIDTH(WIDTH), .LOCK_CNT(LOCK_CNT),
    .LOSS_CNT(LOSS_CNT), .ERR_W(8)
  ) u_dut8 (
    .clk(clk), .rst_n(rst_n), .rx(rx),
    .clear(clear), .locked(locked_a),
    .err_pulse(pulse_a), .err_count(cnt_a),
    .state(state_a), .expected(exp_a)
  );

  count_stream_checker #(
    .WIDTH(WIDTH), .LOCK_CNT(LOCK_CNT),
    .LOSS_CNT(LOSS_CNT), .ERR_W(2)
  ) u_dut2 (
    .clk(clk), .rst_n(rst_n), .rx(rx),
    .clear(clear), .locked(locked_b),
    .err_pulse(pulse_b), .err_count(cnt_b),
    .state(state_b), .expected(exp_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference model: 0=HUNT 1=SYNC 2=LOCKED 3=SLIP
  int m_st, m_exp, m_good, m_bad;
  int m_cnt8, m_cnt2, m_pulse;

  function automatic void m_reset();
    m_st = 0; m_exp = 0; m_good = 0; m_bad = 0;
    m_cnt8 = 0; m_cnt2 = 0; m_pulse = 0;
  endfunction

  function automatic void m_step(int e, int d, int c);
    int hit;
    hit = 0;
    if (e != 0) begin
      if (m_st == 0) begin
        m_exp = (d + 1) % 256; m_good = 0; m_st = 1;
      end else if (m_st == 1) begin
        if (d == m_exp) begin
          m_good++;
          if (m_good == LOCK_CNT) begin
            m_good = 0; m_st = 2;
          end
        end else m_good = 0;
        m_exp = (d + 1) % 256;
      end else begin
        if (d == m_exp) begin
          m_bad = 0; m_st = 2;
        end else begin
          hit = 1;
          m_bad++;
          m_st = 3;
          if (m_bad == LOSS_CNT) begin
            m_bad = 0; m_st = 0;
          end
        end
        m_exp = (m_exp + 1) % 256;
      end
    end
    m_pulse = hit;
    if (c != 0) begin
      m_cnt8 = 0; m_cnt2 = 0;
    end else if (hit != 0) begin
      if (m_cnt8 < 255) m_cnt8++;
      if (m_cnt2 < 3) m_cnt2++;
    end
  endfunction

  task automatic chk(string tag, int obs, int req);
    checks++;
    assert (obs === req) else begin
      errors++;
      $error("FAIL %s observed=%0h required=%0h", tag, obs, req);
    end
  endtask

  task automatic chk_all(string tag);
    chk({tag, ".state"}, int'(state_a), m_st);
    chk({tag, ".exp"}, int'(exp_a), m_exp);
    chk({tag, ".locked"}, int'(locked_a), (m_st >= 2) ? 1 : 0);
    chk({tag, ".pulse"}, int'(pulse_a), m_pulse);
    chk({tag, ".cnt8"}, int'(cnt_a), m_cnt8);
    chk({tag, ".state2"}, int'(state_b), m_st);
    chk({tag, ".exp2"}, int'(exp_b), m_exp);
    chk({tag, ".pulse2"}, int'(pulse_b), m_pulse);
    chk({tag, ".cnt2"}, int'(cnt_b), m_cnt2);
  endtask

  // drive one cycle, clock it, check #1 after the edge
  task automatic smp(int e, int d, int c, string tag);
    rx.en      = e[0];
    rx.data_in = d[7:0];
    clear      = c[0];
    @(posedge clk);
    m_step(e, d, c);
    #1;
    chk_all(tag);
  endtask

  task automatic feed(int from, int n, string tag);
    for (int i = 0; i < n; i++) smp(1, (from + i) % 256, 0, tag);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    m_reset();
    chk_all("rst_async");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int d, r;
    rst_n = 1'b1;
    clear = 1'b0;
    rx.en = 1'b0;
    rx.data_in = '0;
    #2;
    do_reset();

    // lock acquisition
    smp(1, 8'h10, 0, "acq0");
    chk("acq0.sync", int'(state_a), 1);
    feed(8'h11, 3, "acq");
    chk("acq3.unlocked", int'(locked_a), 0);
    smp(1, 8'h14, 0, "acq4");
    chk("acq4.locked", int'(locked_a), 1);
    chk("acq4.exp", int'(exp_a), 8'h15);
    chk("acq4.cnt", int'(cnt_a), 0);

    // wrap-around
    do_reset();
    feed(8'hFB, 5, "wrap_lock");
    chk("wrap.locked", int'(locked_a), 1);
    smp(1, 8'h00, 0, "wrap0");
    smp(1, 8'h01, 0, "wrap1");
    chk("wrap.state", int'(state_a), 2);
    chk("wrap.pulse", int'(pulse_a), 0);
    chk("wrap.exp", int'(exp_a), 8'h02);

    // single glitch recovery
    feed(8'h02, 8'h1E, "glitch_pre");
    chk("glitch.exp0", int'(exp_a), 8'h20);
    smp(1, 8'h55, 0, "glitch_bad");
    chk("glitch.pulse", int'(pulse_a), 1);
    chk("glitch.slip", int'(state_a), 3);
    chk("glitch.lk", int'(locked_a), 1);
    chk("glitch.cnt", int'(cnt_a), 1);
    smp(1, 8'h21, 0, "glitch_ok");
    chk("glitch.pulse_off", int'(pulse_a), 0);
    chk("glitch.relock", int'(state_a), 2);
    chk("glitch.exp", int'(exp_a), 8'h22);

    // loss of lock
    feed(8'h22, 8'h1E, "loss_pre");
    chk("loss.exp0", int'(exp_a), 8'h40);
    for (int i = 0; i < 3; i++) smp(1, 0, 0, "loss");
    chk("loss.cnt", int'(cnt_a), 4);
    chk("loss.hunt", int'(state_a), 0);
    chk("loss.locked", int'(locked_a), 0);
    feed(0, 5, "relock");
    chk("relock.lk", int'(locked_a), 1);
    chk("relock.exp", int'(exp_a), 8'h05);

    // en=0 window holds everything
    for (int i = 0; i < 5; i++) smp(0, $urandom_range(255), 0, "en_off");
    chk("en_off.exp", int'(exp_a), 8'h05);
    chk("en_off.state", int'(state_a), 2);

    // clear with en low, then 5 errors (alternating slip/recover)
    smp(0, 0, 1, "clr");
    chk("clr.cnt", int'(cnt_a), 0);
    d = 5;
    for (int k = 0; k < 5; k++) begin
      smp(1, 8'hAA, (k == 4) ? 1 : 0, "sat_err");
      chk("sat.pulse", int'(pulse_b), 1);
      d = (d + 1) % 256;
      if (k < 4) begin
        smp(1, d, 0, "sat_ok");
        d = (d + 1) % 256;
      end
    end
    chk("sat.cnt2_cleared", int'(cnt_b), 0);
    chk("sat.cnt8_cleared", int'(cnt_a), 0);

    // randomized mix: mostly correct words, some glitches
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(99);
      d = (r < 80) ? m_exp : $urandom_range(255);
      smp(($urandom_range(9) != 0) ? 1 : 0, d,
          ($urandom_range(49) == 0) ? 1 : 0, "rand");
    end

    // async reset while in SLIP with err_count=2
    do_reset();
    feed(8'h30, 5, "ar_lock");
    smp(1, 8'h00, 0, "ar_e1");
    smp(1, 8'h36, 0, "ar_ok");
    smp(1, 8'h00, 0, "ar_e2");
    chk("ar.slip", int'(state_a), 3);
    chk("ar.cnt", int'(cnt_a), 2);
    #3;
    rst_n = 1'b0;
    #1;
    m_reset();
    chk("ar.state", int'(state_a), 0);
    chk("ar.locked", int'(locked_a), 0);
    chk("ar.cnt0", int'(cnt_a), 0);
    chk("ar.exp0", int'(exp_a), 0);
    chk_all("ar_all");
    @(negedge clk);
    rst_n = 1'b1;
    smp(1, 8'h77, 0, "ar_post");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
